// File: rtl/vvm_cfg_sequencer.sv
// Purpose : stages DSP configuration writes and commits them atomically on apply,
//           running an optional DSP reset, one FTW load pulse and a settle window.
// Latency : capture edge -> LOAD next cycle (or after RST_CYCLES of dsp_rst when the CIC
//           config changed) -> SETTLE_DECIMS*cic_period cycles -> IDLE with meas_valid.
// Backpressure: none on writes (accepted every cycle); an apply while busy is held in a
//           one-deep pending flag and replayed on the first IDLE cycle.
// Ports   : sample_clk/sample_rst   clock, async active-high reset
//           cfg_we/cfg_sel/cfg_data staging write port (sel 0-3 FTW, 4 period, 5 cic shift, 6 iir shift)
//           apply                   commit request (level-sampled)
//           busy/meas_valid         sequencer status
//           ftws..ftws_3, update_ftw, cic_period, cic_shift, iir_shift, dsp_rst  active DSP config
module vvm_cfg_sequencer #(
  parameter int          RST_CYCLES     = 16,
  parameter int          SETTLE_DECIMS  = 32,
  parameter logic [12:0] CIC_PERIOD_RST = 13'd100,
  parameter logic [3:0]  CIC_SHIFT_RST  = 4'd2,
  parameter logic [5:0]  IIR_SHIFT_RST  = 6'd4
) (
  input  logic        sample_clk,
  input  logic        sample_rst,
  input  logic        cfg_we,
  input  logic [2:0]  cfg_sel,
  input  logic [31:0] cfg_data,
  input  logic        apply,
  output logic        busy,
  output logic        meas_valid,
  output logic [31:0] ftws,
  output logic [31:0] ftws_1,
  output logic [31:0] ftws_2,
  output logic [31:0] ftws_3,
  output logic        update_ftw,
  output logic [12:0] cic_period,
  output logic [3:0]  cic_shift,
  output logic [5:0]  iir_shift,
  output logic        dsp_rst
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RST    = 2'd1,
    S_LOAD   = 2'd2,
    S_SETTLE = 2'd3
  } state_t;

  localparam logic [15:0] RST_LAST = 16'(RST_CYCLES - 1);
  localparam logic [15:0] DEC_LAST = 16'(SETTLE_DECIMS - 1);

  state_t             state_q, state_d;

  // staging copy, written by the cfg port
  logic [3:0][31:0]   stg_ftw_q, stg_ftw_d;
  logic [12:0]        stg_period_q, stg_period_d;
  logic [3:0]         stg_cshift_q, stg_cshift_d;
  logic [5:0]         stg_ishift_q, stg_ishift_d;
  logic               dirty_q, dirty_d;

  // active copy, driven to the DSP
  logic [3:0][31:0]   act_ftw_q, act_ftw_d;
  logic [12:0]        act_period_q, act_period_d;
  logic [3:0]         act_cshift_q, act_cshift_d;
  logic [5:0]         act_ishift_q, act_ishift_d;

  logic               pend_q, pend_d;
  logic               meas_q, meas_d;
  logic [15:0]        rst_cnt_q, rst_cnt_d;
  logic [12:0]        dec_cnt_q, dec_cnt_d;   // inner: one CIC output period
  logic [15:0]        win_cnt_q, win_cnt_d;   // outer: number of CIC outputs

  always_comb begin
    // staging update; computed first so a same-cycle write is seen by a capture
    stg_ftw_d    = stg_ftw_q;
    stg_period_d = stg_period_q;
    stg_cshift_d = stg_cshift_q;
    stg_ishift_d = stg_ishift_q;
    dirty_d      = dirty_q;
    if (cfg_we) begin
      case (cfg_sel)
        3'd0, 3'd1, 3'd2, 3'd3: stg_ftw_d[cfg_sel[1:0]] = cfg_data;
        3'd4: begin
          // a period below 2 would make the settle window degenerate
          stg_period_d = (cfg_data[12:0] < 13'd2) ? 13'd2 : cfg_data[12:0];
          dirty_d      = 1'b1;
        end
        3'd5: begin
          stg_cshift_d = cfg_data[3:0];
          dirty_d      = 1'b1;
        end
        3'd6:    stg_ishift_d = cfg_data[5:0];
        default: ;
      endcase
    end

    state_d      = state_q;
    act_ftw_d    = act_ftw_q;
    act_period_d = act_period_q;
    act_cshift_d = act_cshift_q;
    act_ishift_d = act_ishift_q;
    pend_d       = pend_q;
    meas_d       = meas_q;
    rst_cnt_d    = '0;
    dec_cnt_d    = '0;
    win_cnt_d    = '0;

    case (state_q)
      S_IDLE: begin
        if (apply || pend_q) begin
          act_ftw_d    = stg_ftw_d;
          act_period_d = stg_period_d;
          act_cshift_d = stg_cshift_d;
          act_ishift_d = stg_ishift_d;
          pend_d       = 1'b0;
          meas_d       = 1'b0;
          state_d      = dirty_d ? S_RST : S_LOAD;
          dirty_d      = 1'b0;
        end
      end
      S_RST: begin
        if (rst_cnt_q == RST_LAST) begin
          state_d = S_LOAD;
        end else begin
          rst_cnt_d = rst_cnt_q + 16'd1;
        end
      end
      S_LOAD: begin
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        dec_cnt_d = dec_cnt_q + 13'd1;
        win_cnt_d = win_cnt_q;
        if (dec_cnt_q == act_period_q - 13'd1) begin
          dec_cnt_d = '0;
          if (win_cnt_q == DEC_LAST) begin
            state_d = S_IDLE;
            // a queued apply is replayed next cycle, so the new config never looks settled
            meas_d  = !(pend_q || apply);
          end else begin
            win_cnt_d = win_cnt_q + 16'd1;
          end
        end
      end
      default: state_d = S_RST;
    endcase

    if (apply && (state_q != S_IDLE)) begin
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge sample_clk or posedge sample_rst) begin
    if (sample_rst) begin
      state_q      <= S_RST;
      stg_ftw_q    <= '0;
      stg_period_q <= CIC_PERIOD_RST;
      stg_cshift_q <= CIC_SHIFT_RST;
      stg_ishift_q <= IIR_SHIFT_RST;
      dirty_q      <= 1'b0;
      act_ftw_q    <= '0;
      act_period_q <= CIC_PERIOD_RST;
      act_cshift_q <= CIC_SHIFT_RST;
      act_ishift_q <= IIR_SHIFT_RST;
      pend_q       <= 1'b0;
      meas_q       <= 1'b0;
      rst_cnt_q    <= '0;
      dec_cnt_q    <= '0;
      win_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      stg_ftw_q    <= stg_ftw_d;
      stg_period_q <= stg_period_d;
      stg_cshift_q <= stg_cshift_d;
      stg_ishift_q <= stg_ishift_d;
      dirty_q      <= dirty_d;
      act_ftw_q    <= act_ftw_d;
      act_period_q <= act_period_d;
      act_cshift_q <= act_cshift_d;
      act_ishift_q <= act_ishift_d;
      pend_q       <= pend_d;
      meas_q       <= meas_d;
      rst_cnt_q    <= rst_cnt_d;
      dec_cnt_q    <= dec_cnt_d;
      win_cnt_q    <= win_cnt_d;
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign dsp_rst    = (state_q == S_RST);
  assign update_ftw = (state_q == S_LOAD);
  assign meas_valid = meas_q;
  assign ftws       = act_ftw_q[0];
  assign ftws_1     = act_ftw_q[1];
  assign ftws_2     = act_ftw_q[2];
  assign ftws_3     = act_ftw_q[3];
  assign cic_period = act_period_q;
  assign cic_shift  = act_cshift_q;
  assign iir_shift  = act_ishift_q;

endmodule

// File: tb/tb_vvm_cfg_sequencer.sv
// Directed bench for vvm_cfg_sequencer with default parameters.
module tb_vvm_cfg_sequencer;

  logic        sample_clk = 1'b0;
  logic        sample_rst = 1'b1;
  logic        cfg_we     = 1'b0;
  logic [2:0]  cfg_sel    = 3'd0;
  logic [31:0] cfg_data   = 32'd0;
  logic        apply      = 1'b0;
  logic        busy, meas_valid, update_ftw, dsp_rst;
  logic [31:0] ftws, ftws_1, ftws_2, ftws_3;
  logic [12:0] cic_period;
  logic [3:0]  cic_shift;
  logic [5:0]  iir_shift;

  int n_vec = 0;
  int n_err = 0;

  vvm_cfg_sequencer dut (
    .sample_clk (sample_clk),
    .sample_rst (sample_rst),
    .cfg_we     (cfg_we),
    .cfg_sel    (cfg_sel),
    .cfg_data   (cfg_data),
    .apply      (apply),
    .busy       (busy),
    .meas_valid (meas_valid),
    .ftws       (ftws),
    .ftws_1     (ftws_1),
    .ftws_2     (ftws_2),
    .ftws_3     (ftws_3),
    .update_ftw (update_ftw),
    .cic_period (cic_period),
    .cic_shift  (cic_shift),
    .iir_shift  (iir_shift),
    .dsp_rst    (dsp_rst)
  );

  always #5 sample_clk = ~sample_clk;

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // advance n cycles; leaves time 1 unit after the rising edge
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge sample_clk);
      #1;
    end
  endtask

  task automatic cfg_write(input logic [2:0] sel, input logic [31:0] d);
    cfg_we   = 1'b1;
    cfg_sel  = sel;
    cfg_data = d;
    tick();
    cfg_we   = 1'b0;
  endtask

  task automatic pulse_apply();
    apply = 1'b1;
    tick();
    apply = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk_val({tag, " ftws"},       ftws,       32'd0);
    chk_val({tag, " ftws_1"},     ftws_1,     32'd0);
    chk_val({tag, " ftws_2"},     ftws_2,     32'd0);
    chk_val({tag, " ftws_3"},     ftws_3,     32'd0);
    chk_val({tag, " cic_period"}, cic_period, 32'd100);
    chk_val({tag, " cic_shift"},  cic_shift,  32'd2);
    chk_val({tag, " iir_shift"},  iir_shift,  32'd4);
    chk_val({tag, " dsp_rst"},    dsp_rst,    32'd1);
    chk_val({tag, " update_ftw"}, update_ftw, 32'd0);
    chk_val({tag, " busy"},       busy,       32'd1);
    chk_val({tag, " meas_valid"}, meas_valid, 32'd0);
  endtask

  // Starts on the first cycle after capture (RST or LOAD) and follows the sequence to IDLE.
  task automatic run_seq(input string tag, input int exp_rst, input int exp_settle);
    int n;
    int extra_upd;
    n = 0;
    while (dsp_rst && n < 100) begin
      n++;
      tick();
    end
    chk_val({tag, " rst_len"}, n, exp_rst);
    chk_val({tag, " load_pulse"}, update_ftw, 32'd1);
    tick();
    n = 0;
    extra_upd = 0;
    while (busy && n < 40000) begin
      if (update_ftw) extra_upd++;
      n++;
      tick();
    end
    chk_val({tag, " settle_len"}, n, exp_settle);
    chk_val({tag, " extra_update"}, extra_upd, 32'd0);
    chk_val({tag, " meas_valid"}, meas_valid, 32'd1);
  endtask

  task automatic count_busy(input string tag, input int cycles);
    int nb;
    nb = 0;
    repeat (cycles) begin
      if (busy) nb++;
      tick();
    end
    chk_val({tag, " stays_idle"}, nb, 32'd0);
  endtask

  initial begin
    int n;

    // reset held, then start-up sequence
    tick(3);
    chk_reset_outputs("reset");
    sample_rst = 1'b0;
    run_seq("startup", 16, 3200);

    // FTW only: no DSP reset
    cfg_write(3'd2, 32'h0D9C_7000);
    chk_val("ftw stage_only", ftws_2, 32'd0);
    pulse_apply();
    chk_val("ftw capture", ftws_2, 32'h0D9C_7000);
    chk_val("ftw meas_drop", meas_valid, 32'd0);
    chk_val("ftw no_dsp_rst", dsp_rst, 32'd0);
    run_seq("ftw", 0, 3200);

    // new CIC period
    cfg_write(3'd4, 32'd1000);
    chk_val("per1000 stage_only", cic_period, 32'd100);
    pulse_apply();
    chk_val("per1000 capture", cic_period, 32'd1000);
    run_seq("per1000", 16, 32000);

    // period 0 clamped to 2, written in the same cycle as apply
    cfg_we = 1'b1; cfg_sel = 3'd4; cfg_data = 32'd0; apply = 1'b1;
    tick();
    cfg_we = 1'b0; apply = 1'b0;
    chk_val("per0 clamp", cic_period, 32'd2);
    run_seq("per0", 16, 64);

    // unchanged cic_shift still marks CIC dirty; iir_shift written alongside
    cfg_write(3'd5, 32'd2);
    cfg_write(3'd6, 32'h3F);
    pulse_apply();
    chk_val("same_shift cic_shift", cic_shift, 32'd2);
    chk_val("same_shift iir_shift", iir_shift, 32'h3F);
    run_seq("same_shift", 16, 64);

    // three applies during SETTLE collapse into one further sequence
    pulse_apply();
    tick();
    pulse_apply();
    tick();
    pulse_apply();
    tick(3);
    pulse_apply();
    n = 0;
    while (busy && n < 200) begin
      n++;
      tick();
    end
    chk_val("pend first_idle busy", busy, 32'd0);
    chk_val("pend first_idle meas", meas_valid, 32'd0);
    tick();
    chk_val("pend restart busy", busy, 32'd1);
    run_seq("pend_seq", 0, 64);
    count_busy("pend", 30);

    // reset mid-SETTLE with a pending apply and dirty staging
    pulse_apply();
    tick(5);
    pulse_apply();
    cfg_write(3'd0, 32'h1234);
    cfg_write(3'd4, 32'd500);
    sample_rst = 1'b1;
    #1;
    chk_reset_outputs("midrst");
    tick(2);
    sample_rst = 1'b0;
    run_seq("midrst_restart", 16, 3200);
    count_busy("midrst", 30);
    pulse_apply();
    chk_val("midrst stg_ftw0", ftws, 32'd0);
    chk_val("midrst stg_period", cic_period, 32'd100);
    chk_val("midrst dirty_clear", dsp_rst, 32'd0);
    chk_val("midrst busy", busy, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
